if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 74 +++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC select, IF/ID register and optional PC_BOUND_CHECK_EN halt
module if_stage #(
    parameter int WIDTH_I = 32,
    parameter int DEPTH_I = 256,
    parameter logic [WIDTH_I-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [WIDTH_I-1:0] branch_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    input  logic [WIDTH_I-1:0] i_in,
    output logic               cs_rom,
    output logic [WIDTH_I-1:0] pc_addr,
    output logic [WIDTH_I-1:0] if_id_instr,
    output logic [WIDTH_I-1:0] if_id_pc4,
    output logic               if_id_valid,
    output logic               halted
);
`ifdef PC_BOUND_CHECK_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    localparam logic [WIDTH_I-1:0] MAX_PC = WIDTH_I'(DEPTH_I - 4);
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif
    state_t state, state_n;
    logic [WIDTH_I-1:0] pc4, jmp, pc_n;
    logic redirect;
    assign pc4 = pc_addr + WIDTH_I'(4);
    assign jmp = {pc4[WIDTH_I-1:28], jump_index, 2'b00};
    assign redirect = branch_taken | jump;
    assign pc_n = branch_taken ? branch_target : jump ? jmp : stall ? pc_addr : pc4;
`ifdef PC_BOUND_CHECK_EN
    assign halted = state == HALT;
`else
    assign halted = 1'b0;
`endif
    // next state and chip select; an illegal next PC parks the fetch in HALT
    always_comb begin
        state_n = state;
        cs_rom = state == RUN;
`ifdef PC_BOUND_CHECK_EN
        state_n = state == BOOT ? RUN :
                  (state == RUN && (pc_n > MAX_PC || pc_n[1:0] != 2'b00)) ? HALT : state;
`else
        state_n = RUN;
`endif
    end
    // state, PC and IF/ID register; redirects and non-RUN cycles insert bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc_addr <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc4 <= '0;
            if_id_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (state == RUN && state_n == RUN) pc_addr <= pc_n;
            if (state != RUN || redirect || flush) begin
                if_id_instr <= '0;
                if_id_pc4 <= '0;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_instr <= i_in;
                if_id_pc4 <= pc4;
                if_id_valid <= 1'b1;
            end
        end
    end
endmodule
